// File: rtl/wind_decoder_pkg.sv
// Shared constants for the wind decoder: light patterns, wind codes, FSM states.
// Optional WIND_DECODER_STATS_EN adds an error counter port in wind_decoder.
package wind_pkg;
  localparam logic [2:0] PAT_A = 3'b001;
  localparam logic [2:0] PAT_B = 3'b010;
  localparam logic [2:0] PAT_C = 3'b100;
  localparam logic [2:0] PAT_D = 3'b101;

  localparam logic [1:0] WIND_CALM = 2'b00;
  localparam logic [1:0] WIND_R2L  = 2'b01;
  localparam logic [1:0] WIND_L2R  = 2'b10;

  typedef enum logic [1:0] {EMPTY, TRACK, LOCK} state_t;

  function automatic logic is_legal_pat(input logic [2:0] p);
    return (p == PAT_A) || (p == PAT_B) || (p == PAT_C) || (p == PAT_D);
  endfunction
endpackage

// File: rtl/wind_decoder_if.sv
// Light pattern in / wind state out bundle; err_cnt exists only with WIND_DECODER_STATS_EN.
interface wind_decoder_if;
  logic       pat_valid;
  logic [2:0] pat;
  logic [1:0] w_out;
  logic       w_valid;
  logic       err;
  logic       locked;
`ifdef WIND_DECODER_STATS_EN
  logic [7:0] err_cnt;

  modport master (output pat_valid, pat, input w_out, w_valid, err, locked, err_cnt);
  modport slave  (input pat_valid, pat, output w_out, w_valid, err, locked, err_cnt);
`else
  modport master (output pat_valid, pat, input w_out, w_valid, err, locked);
  modport slave  (input pat_valid, pat, output w_out, w_valid, err, locked);
`endif
endinterface

// File: rtl/wind_decoder_xlate.sv
// Combinational decode of a (prev, curr) pattern pair into a wind code.
// prev is always a previously accepted legal pattern, so only curr is range-checked.
module wind_xlate
  import wind_pkg::*;
(
  input  logic [2:0] i_prev,
  input  logic [2:0] i_curr,
  output logic       o_legal_pat,
  output logic       o_legal_trans,
  output logic [1:0] o_w
);
  always_comb begin
    o_legal_pat   = is_legal_pat(i_curr);
    o_legal_trans = 1'b0;
    o_w           = WIND_CALM;
    case ({i_prev, i_curr})
      {PAT_A, PAT_D}, {PAT_B, PAT_D}, {PAT_C, PAT_D}, {PAT_D, PAT_B}: begin
        o_legal_trans = 1'b1;
        o_w           = WIND_CALM;
      end
      {PAT_A, PAT_B}, {PAT_B, PAT_C}, {PAT_C, PAT_A}, {PAT_D, PAT_A}: begin
        o_legal_trans = 1'b1;
        o_w           = WIND_R2L;
      end
      {PAT_A, PAT_C}, {PAT_B, PAT_A}, {PAT_C, PAT_B}, {PAT_D, PAT_C}: begin
        o_legal_trans = 1'b1;
        o_w           = WIND_L2R;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/wind_decoder.sv
// Recovers wind codes from the light pattern stream, 1-cycle registered latency, no backpressure.
// WIND_DECODER_STATS_EN adds a saturating 8-bit err_cnt output.
module wind_decoder
  import wind_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 4
) (
  input  logic          clk,
  input  logic          reset,
  wind_decoder_if.slave bus
);
  localparam logic [CNT_W-1:0] LOCK_C = LOCK_COUNT[CNT_W-1:0];

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_prev, w_prev_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_w_out, w_w_out_nxt;
  logic             r_w_valid, w_w_valid_nxt;
  logic             r_err, w_err_nxt;

  logic       w_legal_pat;
  logic       w_legal_trans;
  logic [1:0] w_dec;

  wind_xlate u_xlate (
    .i_prev        (r_prev),
    .i_curr        (bus.pat),
    .o_legal_pat   (w_legal_pat),
    .o_legal_trans (w_legal_trans),
    .o_w           (w_dec)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_prev_nxt    = r_prev;
    w_cnt_nxt     = r_cnt;
    w_w_out_nxt   = r_w_out;
    w_w_valid_nxt = 1'b0;
    w_err_nxt     = 1'b0;
    if (bus.pat_valid) begin
      case (r_state)
        EMPTY: begin
          if (w_legal_pat) begin
            w_prev_nxt  = bus.pat;
            w_state_nxt = TRACK;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: begin
          if (!w_legal_pat) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = EMPTY;
            w_cnt_nxt   = '0;
          end else if (!w_legal_trans) begin
            w_err_nxt   = 1'b1;
            w_prev_nxt  = bus.pat;
            w_state_nxt = TRACK;
            w_cnt_nxt   = '0;
          end else begin
            w_w_out_nxt   = w_dec;
            w_w_valid_nxt = 1'b1;
            w_prev_nxt    = bus.pat;
            // A zero count means w_out is stale (after an error), so restart the run.
            if (w_dec == r_w_out && r_cnt != '0)
              w_cnt_nxt = (r_cnt >= LOCK_C) ? LOCK_C : r_cnt + CNT_W'(1);
            else
              w_cnt_nxt = CNT_W'(1);
            w_state_nxt = (w_cnt_nxt == LOCK_C) ? LOCK : TRACK;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_prev    <= '0;
      r_cnt     <= '0;
      r_w_out   <= WIND_CALM;
      r_w_valid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_prev_nxt;
      r_cnt     <= w_cnt_nxt;
      r_w_out   <= w_w_out_nxt;
      r_w_valid <= w_w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.w_out   = r_w_out;
  assign bus.w_valid = r_w_valid;
  assign bus.err     = r_err;
  assign bus.locked  = (r_state == LOCK);

`ifdef WIND_DECODER_STATS_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_err_cnt <= '0;
    else if (w_err_nxt && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_wind_decoder.sv
// Randomized bench for wind_decoder against a pair-table reference model.
module tb_wind_decoder;
  localparam int LOCK_COUNT = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  wind_decoder_if bus ();

  wind_decoder #(.LOCK_COUNT(LOCK_COUNT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: list of legal (prev, curr, wind) triples straight from the decode table.
  int tbl [12][3] = '{
    '{1, 5, 0}, '{1, 2, 1}, '{1, 4, 2},
    '{2, 5, 0}, '{2, 4, 1}, '{2, 1, 2},
    '{4, 5, 0}, '{4, 1, 1}, '{4, 2, 2},
    '{5, 2, 0}, '{5, 1, 1}, '{5, 4, 2}
  };

  bit m_have, m_wvld, m_err, m_locked;
  int m_prev, m_wout, m_run, m_errcnt;

  function automatic int ref_dec(int p, int c);
    for (int i = 0; i < 12; i++)
      if (tbl[i][0] == p && tbl[i][1] == c) return tbl[i][2];
    return -1;
  endfunction

  function automatic bit ref_legal(int p);
    return (p == 1) || (p == 2) || (p == 4) || (p == 5);
  endfunction

  task automatic model(input bit rst, input bit v, input int p);
    int d;
    m_wvld = 0;
    m_err  = 0;
    if (rst) begin
      m_have = 0; m_prev = 0; m_wout = 0; m_run = 0; m_errcnt = 0;
    end else if (v) begin
      if (!m_have) begin
        if (ref_legal(p)) begin m_have = 1; m_prev = p; end
        else m_err = 1;
      end else if (!ref_legal(p)) begin
        m_err = 1; m_have = 0; m_run = 0;
      end else begin
        d = ref_dec(m_prev, p);
        m_prev = p;
        if (d < 0) begin
          m_err = 1; m_run = 0;
        end else begin
          m_run  = (d == m_wout && m_run > 0) ? m_run + 1 : 1;
          m_wout = d;
          m_wvld = 1;
        end
      end
      if (m_err && m_errcnt < 255) m_errcnt++;
    end
    m_locked = m_have && (m_run >= LOCK_COUNT);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [2:0] p);
    @(negedge clk);
    reset         = rst;
    bus.pat_valid = v;
    bus.pat       = p;
    @(posedge clk);
    #1;
    model(rst, v, int'(p));
    chk("w_valid", int'(bus.w_valid), int'(m_wvld));
    chk("err", int'(bus.err), int'(m_err));
    chk("locked", int'(bus.locked), int'(m_locked));
    chk("w_out", int'(bus.w_out), m_wout);
`ifdef WIND_DECODER_STATS_EN
    chk("err_cnt", int'(bus.err_cnt), m_errcnt);
`endif
  endtask

  task automatic seq(input logic [2:0] pats[$]);
    foreach (pats[i]) step(0, 1, pats[i]);
  endtask

  initial begin
    reset = 1'b1;
    bus.pat_valid = 1'b0;
    bus.pat = 3'b000;
    step(1, 0, 3'b000);
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_w_out", int'(bus.w_out), 0);

    seq('{3'b001, 3'b101, 3'b010, 3'b101});
    chk("tp1_locked", int'(bus.locked), 1);
    seq('{3'b010});

    step(1, 0, 3'b000);
    seq('{3'b001, 3'b010, 3'b100, 3'b001});
    chk("tp2_w_out", int'(bus.w_out), 1);
    chk("tp2_locked", int'(bus.locked), 1);

    step(1, 0, 3'b000);
    seq('{3'b001, 3'b100, 3'b010, 3'b001, 3'b100, 3'b101});
    chk("tp3_unlock", int'(bus.locked), 0);
    chk("tp3_w_out", int'(bus.w_out), 0);

    seq('{3'b001, 3'b100, 3'b010, 3'b001, 3'b011});
    chk("tp4_err", int'(bus.err), 1);
    seq('{3'b010, 3'b101});

    step(1, 0, 3'b000);
    seq('{3'b010, 3'b010});
    chk("tp5_err", int'(bus.err), 1);
    seq('{3'b100});
    chk("tp5_w_out", int'(bus.w_out), 1);

    seq('{3'b001, 3'b010});
    for (int i = 0; i < 5; i++) step(0, 0, 3'(i));
    seq('{3'b100, 3'b001});
    step(1, 1, 3'b010);
    chk("midrst_locked", int'(bus.locked), 0);

    for (int i = 0; i < 1500; i++) begin
      logic [2:0] p;
      int sel;
      sel = $urandom_range(0, 9);
      case ($urandom_range(0, 3))
        0: p = 3'b001;
        1: p = 3'b010;
        2: p = 3'b100;
        default: p = 3'b101;
      endcase
      if (sel == 0) p = 3'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, p);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/wind_decoder.md
Name: wind_decoder

Overview:
- Receive-side counterpart of the wind-driven light sequencer.
- Samples the 3-bit light pattern stream and recovers the 2-bit wind code that produced each step.
- Flags illegal patterns and illegal transitions.
- Asserts a lock indication once the same direction has been decoded repeatedly.
- Sits between the light pattern bus and downstream frog/hazard logic that needs the wind state.

Parameters:
LOCK_COUNT, 3, number of consecutive identical legal decodes required to assert locked (legal range 1..15).
CNT_W, 4, width of the internal consistency counter; must hold LOCK_COUNT.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  synchronous, active-high reset.
pat_valid  input  1  qualifies pat for this cycle.
pat  input  3  light pattern sample.
w_out  output  2  last decoded wind code: 00 calm, 01 right-to-left, 10 left-to-right.
w_valid  output  1  one-cycle pulse; w_out updated this cycle.
err  output  1  one-cycle pulse; illegal pattern or illegal transition.
locked  output  1  level; direction stable for LOCK_COUNT decodes.
err_cnt  output  8  saturating error count; present only with WIND_DECODER_STATS_EN.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: w_out=00, w_valid=0, err=0, locked=0, count=0, state=EMPTY. err_cnt=0 when the feature is compiled in.
- Legal patterns: A=001, B=010, C=100, D=101. Any other value is illegal.
- Decode table, prev -> curr gives w:
  - A->D 00, A->B 01, A->C 10.
  - B->D 00, B->C 01, B->A 10.
  - C->D 00, C->A 01, C->B 10.
  - D->B 00, D->A 01, D->C 10.
  - All other legal pairs are illegal transitions, e.g. a repeated pattern.
- Timing: all outputs are registered. Results appear on the cycle after the pat_valid edge that samples the pattern, so latency is 1 clock.
- pat_valid=0: state, prev, count and w_out hold; w_valid=0 and err=0.
- States:
  - EMPTY: no reference pattern.
    - Legal pat: store prev, go TRACK, no w_valid.
    - Illegal pat: err pulse, stay EMPTY.
  - TRACK / LOCK, on pat_valid:
    - Illegal pat: err pulse, go EMPTY, count=0, locked=0. w_out holds.
    - Legal pat, illegal transition: err pulse, prev<=pat, go TRACK, count=0, locked=0.
    - Legal transition: w_out<=decoded, w_valid pulse, prev<=pat.
      - If decoded==w_out and count>0: count<=min(count+1, LOCK_COUNT). Otherwise count<=1.
      - When the new count equals LOCK_COUNT, go LOCK.
      - In LOCK, a differing decode returns to TRACK with count=1.
- locked is 1 exactly while state==LOCK. It is updated in the same cycle as the w_valid/err that causes the change.
- LOCK_COUNT=1: LOCK is entered on the first legal transition.
- Reset asserted mid-stream: all registers take their reset values on that edge, and any pat_valid in that cycle is ignored.

Optional Feature:
- Macro WIND_DECODER_STATS_EN.
- Defined: err_cnt port exists. It increments by 1 on every err pulse, saturates at 255, and is cleared only by reset.
- Undefined: err_cnt port and counter are absent; all other behaviour is identical.

Decomposition:
- Package wind_pkg holds:
  - pattern constants PAT_A/PAT_B/PAT_C/PAT_D;
  - wind codes WIND_CALM=00, WIND_R2L=01, WIND_L2R=10;
  - state enum {EMPTY, TRACK, LOCK}.
- One combinational sub-module, wind_xlate: inputs prev, curr; outputs legal_pat, legal_trans, w. It implements the decode table.
- FSM, counter and output registers stay in wind_decoder.

Test Plan:
- Reset, then pat_valid every cycle with 001,101,010,101,010 -> no w_valid after 1st sample; w_out=00 with w_valid after samples 2–5; locked=1 after sample 4 (3rd decode, LOCK_COUNT=3).
- Sequence 001,010,100,001 -> w_out=01 on each decode; locked=1 after 4th sample; err never asserted.
- Sequence 001,100,010,001,100 -> w_out=10 each decode; then switch to 101 -> w_out=00, locked drops same cycle, count=1.
- While locked, pat=011 -> err=1 for one cycle, locked=0, state EMPTY. Next sample 010 -> no w_valid. Following 101 -> w_out=00.
- 010,010 -> err pulse on the 2nd sample, no w_valid. Next 100 -> w_out=01 (B->C). With WIND_DECODER_STATS_EN defined, err_cnt=1.
- pat_valid low for 5 cycles between samples, and reset asserted mid-sequence -> outputs hold while pat_valid is low; reset returns all outputs to reset values and locked=0 on the next edge.
